// File: rtl/formula_1_arg_pacer.sv
// Argument pacer for the formula 1 FSM: buffers (a,b,c) triples and releases them as
// single-cycle pulses at least GAP cycles apart. Optional macro: FORMULA_1_ARG_PACER_BYPASS_EN.
module formula_1_arg_pacer #(
    parameter int DEPTH = 4,
    parameter int GAP   = 19
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       up_vld,
    output logic                       up_rdy,
    input  logic [31:0]                up_a,
    input  logic [31:0]                up_b,
    input  logic [31:0]                up_c,
    output logic                       arg_vld,
    output logic [31:0]                a,
    output logic [31:0]                b,
    output logic [31:0]                c,
    output logic [$clog2(DEPTH+1)-1:0] fill
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } triple_t;

    triple_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic [GW-1:0]  gap_cnt;
    logic           accept;
    logic           bypass;
    logic           push;
    logic           pop;
    logic           emit;
    triple_t        up_data;

    assign up_rdy  = (cnt != CW'(DEPTH));
    assign fill    = cnt;
    assign accept  = up_vld && up_rdy;
    assign up_data = '{a: up_a, b: up_b, c: up_c};

`ifdef FORMULA_1_ARG_PACER_BYPASS_EN
    // Idle pacer with an expired gap hands the triple straight to the outputs.
    assign bypass = (cnt == '0) && (gap_cnt == '0) && up_vld;
`else
    assign bypass = 1'b0;
`endif

    assign pop  = (cnt != '0) && (gap_cnt == '0);
    assign push = accept && !bypass;
    assign emit = pop || bypass;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= up_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            gap_cnt <= '0;
            arg_vld <= 1'b0;
            a       <= '0;
            b       <= '0;
            c       <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + CW'(push) - CW'(pop);

            // Counter keeps running while empty so a late triple goes out with no extra wait.
            if (emit)
                gap_cnt <= GW'(GAP - 1);
            else if (gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);

            arg_vld <= emit;
            if (bypass) begin
                a <= up_a;
                b <= up_b;
                c <= up_c;
            end else if (pop) begin
                a <= mem[rd_ptr].a;
                b <= mem[rd_ptr].b;
                c <= mem[rd_ptr].c;
            end
        end
    end
endmodule

// File: tb/tb_formula_1_arg_pacer.sv
// Directed bench for formula_1_arg_pacer (DEPTH=4, GAP=19); checks use immediate assertions.
module tb_formula_1_arg_pacer;
    localparam int DEPTH = 4;
    localparam int GAP   = 19;
`ifdef FORMULA_1_ARG_PACER_BYPASS_EN
    localparam int LAT = 0;   // pulse recorded on the accept edge's cycle
`else
    localparam int LAT = 1;   // pulse recorded one edge after accept
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        up_vld = 1'b0;
    logic        up_rdy;
    logic [31:0] up_a = '0, up_b = '0, up_c = '0;
    logic        arg_vld;
    logic [31:0] a, b, c;
    logic [2:0]  fill;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [31:0] qa[$], qb[$], qc[$];
    int          qt[$];

    formula_1_arg_pacer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .up_vld(up_vld), .up_rdy(up_rdy),
        .up_a(up_a), .up_b(up_b), .up_c(up_c),
        .arg_vld(arg_vld), .a(a), .b(b), .c(c), .fill(fill)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Pulse monitor: every arg_vld cycle is logged with its data and edge number.
    always @(negedge clk) begin
        if (arg_vld) begin
            qa.push_back(a); qb.push_back(b); qc.push_back(c); qt.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qa.delete(); qb.delete(); qc.delete(); qt.delete();
    endtask

    task automatic send(input logic [31:0] va, vb, vc, output int acc);
        int n;
        n = 0;
        up_a = va; up_b = vb; up_c = vc; up_vld = 1'b1;
        while (!up_rdy && n < 60) begin
            step();
            n++;
        end
        if (!up_rdy) chk("send_timeout", 32'd1, 32'd0);
        step();
        acc = cyc;
        up_vld = 1'b0;
    endtask

    task automatic wait_pulses(input int n, input int budget);
        while (qt.size() < n && budget > 0) begin
            step();
            budget--;
        end
        chk("pulse_count", qt.size(), n);
    endtask

    initial begin
        int acc, acc2, n;

        // Reset held with up_vld asserted.
        up_vld = 1'b1; up_a = 32'd11; up_b = 32'd12; up_c = 32'd13;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_arg_vld", arg_vld, 0);
            chk("rst_a", a, 0);
            chk("rst_fill", fill, 0);
            chk("rst_up_rdy", up_rdy, 1);
        end
        chk("rst_b", b, 0);
        chk("rst_c", c, 0);
        chk("rst_no_pulse", qt.size(), 0);
        rst = 1'b1; up_vld = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("post_rst_no_pulse", qt.size(), 0);

        // Single triple into an idle pacer.
        send(32'd16, 32'd25, 32'd36, acc);
`ifdef FORMULA_1_ARG_PACER_BYPASS_EN
        chk("single_vld_e", arg_vld, 1);
        chk("single_fill_e", fill, 0);
`else
        chk("single_vld_e", arg_vld, 0);
        chk("single_fill_e", fill, 1);
        step();
        chk("single_vld_e1", arg_vld, 1);
        chk("single_fill_e1", fill, 0);
`endif
        chk("single_a", a, 16);
        chk("single_b", b, 25);
        chk("single_c", c, 36);
        step();
        chk("single_pulse_end", arg_vld, 0);
        chk("single_hold_a", a, 16);
        wait_pulses(1, 5);
        for (int i = 0; i < 25; i++) step();
        chk("single_one_pulse", qt.size(), 1);

        // Burst of 6: fill reaches 4, pop without push when full, then refill.
        clear_q();
        for (int k = 1; k <= 5; k++) send(k, k + 100, k + 200, acc);
        chk("burst_fill4", fill, 4);
        chk("burst_rdy0", up_rdy, 0);
        up_a = 32'd6; up_b = 32'd106; up_c = 32'd206; up_vld = 1'b1;
        n = 0;
        while (fill == 3'd4 && n < 30) begin
            step();
            n++;
        end
        chk("full_pop_fill3", fill, 3);
        chk("full_pop_vld", arg_vld, 1);
        chk("full_pop_rdy", up_rdy, 1);
        step();
        chk("full_push_fill4", fill, 4);
        up_vld = 1'b0;
        wait_pulses(6, 140);
        for (int k = 0; k < 6; k++) begin
            if (k < qt.size()) begin
                chk("burst_a", qa[k], k + 1);
                chk("burst_b", qb[k], k + 101);
                chk("burst_c", qc[k], k + 201);
                if (k > 0) chk("burst_spacing", qt[k] - qt[k-1], GAP);
            end
        end

        // Two triples 30 cycles apart: second goes out at idle latency.
        for (int i = 0; i < 25; i++) step();
        clear_q();
        send(32'd40, 32'd41, 32'd42, acc);
        for (int i = 0; i < 30; i++) step();
        send(32'd50, 32'd51, 32'd52, acc2);
        wait_pulses(2, 10);
        if (qt.size() == 2) begin
            chk("late_first_lat", qt[0] - acc, LAT);
            chk("late_second_lat", qt[1] - acc2, LAT);
            chk("late_second_a", qa[1], 50);
        end

        // Mid-operation reset flushes everything.
        for (int i = 0; i < 25; i++) step();
        send(32'd1, 32'd2, 32'd3, acc);
        send(32'd4, 32'd5, 32'd6, acc);
        send(32'd7, 32'd7, 32'd7, acc);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b0;
        #1;
        clear_q();
        chk("midrst_fill", fill, 0);
        chk("midrst_vld", arg_vld, 0);
        chk("midrst_a", a, 0);
        step();
        step();
        rst = 1'b1;
        send(32'd7, 32'd8, 32'd9, acc);
        wait_pulses(1, 10);
        if (qt.size() >= 1) begin
            chk("after_rst_lat", qt[0] - acc, LAT);
            chk("after_rst_a", qa[0], 7);
            chk("after_rst_b", qb[0], 8);
            chk("after_rst_c", qc[0], 9);
        end
        for (int i = 0; i < 60; i++) step();
        chk("after_rst_no_stale", qt.size(), 1);
        chk("after_rst_fill", fill, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/formula_1_arg_pacer.md
# formula_1_arg_pacer

Upstream argument stage for the formula 1 pipe-aware FSM. It accepts (a, b, c) triples from a producer over a valid/ready handshake and buffers them in a small FIFO. It releases them as single-cycle `arg_vld` pulses spaced at least GAP cycles apart, which matches the FSM's one-triple-per-N+3-cycles acceptance rate. The producer can therefore burst without losing arguments, even though the FSM has no back-pressure of its own.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- GAP, 19: minimum cycles between consecutive `arg_vld` pulses (N+3 for a 16-stage isqrt); ≥ 1.
- clk  input  1: the single clock; all state changes on its rising edge.
- rst  input  1: reset, asynchronous and active-low; clears all state immediately.
- up_vld  input  1: producer has a triple on up_a/up_b/up_c.
- up_rdy  output  1: pacer can take a triple this cycle.
- up_a, up_b, up_c  input  32 each: argument triple.
- arg_vld  output  1: one-cycle pulse; drives the FSM's `arg_vld`.
- a, b, c  output  32 each: triple presented with `arg_vld`; drives FSM a/b/c.
- fill  output  $clog2(DEPTH+1): current FIFO occupancy.

## Operation
- Storage: circular FIFO of DEPTH × 96 bits, with read/write pointers and an occupancy count.
  - Pointers wrap modulo DEPTH.
  - `fill` equals the count.
- Accept rule:
  - `up_rdy = (fill != DEPTH)`, purely from registered state.
  - A beat is accepted on an edge where `up_vld && up_rdy`.
  - When full, no push occurs, even if a pop happens on the same edge.
- Gap counter `gap_cnt`, range 0..GAP-1:
  - On an emit edge it loads GAP-1.
  - Otherwise it decrements while nonzero.
  - Emission is allowed only when `gap_cnt == 0`.
- Emit edge, when `fill != 0 && gap_cnt == 0`:
  - Head entry moves into registered a/b/c.
  - `arg_vld <= 1`; read pointer advances.
- On every other edge `arg_vld <= 0`.
- a/b/c hold the last emitted triple between pulses.
- Simultaneous push and pop with `fill` between 1 and DEPTH-1: count is unchanged and both pointers advance.
- Data is never modified, dropped or reordered; strict FIFO order.
- The FSM is assumed always able to take a pulse spaced ≥ GAP cycles apart; the pacer has no downstream ready input.

## Timing
- Reset values (asynchronous on `rst` low):
  - `arg_vld` = 0; a, b, c = 0.
  - `fill` = 0, so `up_rdy` = 1 combinationally after the reset release.
  - Pointers = 0; `gap_cnt` = 0.
- Reset asserted mid-operation flushes the FIFO and cancels any pending gap. The first emission after release follows the empty-FIFO latency.
- Latency without bypass:
  - Beat accepted on edge E into an empty FIFO with `gap_cnt == 0`.
  - It is popped on edge E+1.
  - `arg_vld` is high in the cycle after E+1.
- Back-to-back emissions under backlog are exactly GAP cycles apart. With GAP = 1, `arg_vld` can stay high on consecutive cycles.
- `gap_cnt` keeps counting while the FIFO is empty. A triple arriving late is emitted as soon as the counter reaches 0, with no extra wait.

## Configuration
- Macro `FORMULA_1_ARG_PACER_BYPASS_EN`.
- Defined: on an edge where `fill == 0 && gap_cnt == 0 && up_vld`:
  - The triple is loaded directly into a/b/c with `arg_vld <= 1` and `gap_cnt <= GAP-1`.
  - It is not written to the FIFO.
  - Latency drops to `arg_vld` high in the cycle after the accept edge E.
- Undefined: every beat passes through the FIFO, with the latency in Timing.
- The handshake (`up_rdy`), ordering and GAP spacing are identical in both builds.

## Test plan
All scenarios use DEPTH = 4, GAP = 19.
- Reset: hold `rst` = 0 for 3 cycles with `up_vld` = 1 -> `arg_vld` = 0, a/b/c = 0, `fill` = 0, `up_rdy` = 1; no emission until `rst` = 1.
- Single triple (a=16, b=25, c=36) into an idle pacer -> one `arg_vld` pulse carrying 16/25/36.
  - Bypass off: 2 edges after acceptance.
  - Bypass on: 1 edge after acceptance.
- Burst of 6 consecutive triples (1..6) -> `up_rdy` drops when `fill` = 4 and reasserts after the first pop. Pulses carry values 1..6 in order, spaced exactly 19 cycles apart.
- Full FIFO with `up_vld` held at 1 across a pop edge -> no push on that edge. `fill` goes 4→3, then the next edge pushes (3→4).
- Two triples accepted 30 cycles apart -> second pulse 1–2 cycles after its acceptance, not 19 cycles after the first.
- Drive `rst` low 5 cycles after accepting 3 triples -> `fill` = 0 and `arg_vld` = 0 immediately. After release, a new triple (7, 8, 9) emits with idle latency; no stale data is ever emitted.
